mul8_rr_sched: RTL and testbench

Round-robin scheduler that shares one sequential 8x8 signed shift-add multiplier core between two requesters. It arbitrates requests, latches operands, converts them to sign/magnitude, sequences the core through its bit-serial add/shift cycles, restores the result sign, and returns the product on a single response channel tagged with the requester id. It sits between the two operand-producing clients and the multiplier datapath.

---
 rtl/mul8_pkg.sv | 24 ++
 rtl/mul8_shift_add_core.sv | 34 +++
 rtl/mul8_rr_sched.sv | 125 ++++++++++++
 tb/tb_mul8_rr_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// Shared types and helpers for the two-requester shift-add multiplier scheduler.
package mul8_pkg;

  localparam int MUL_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SIGN,
    S_RESP
  } state_t;

  typedef logic req_id_t;

  // Unsigned magnitude of a two's-complement operand; the most negative value
  // maps onto its own bit pattern (e.g. -128 -> 0x80), which is its true magnitude.
  function automatic logic [MUL_W-1:0] magnitude(input logic signed [MUL_W-1:0] v);
    logic [MUL_W-1:0] m;
    m = v[MUL_W-1] ? $unsigned(-v) : $unsigned(v);
    return m;
  endfunction

endpackage

// File: rtl/mul8_shift_add_core.sv
// Bit-serial unsigned shift-add multiplier: one multiplier bit consumed per step.
module mul8_shift_add_core
  import mul8_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic                 clk,
  input  logic                 start,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic [2*WIDTH-1:0]   mag_product
);

  logic [2*WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] acc_p1;

  // Load on start, then add the shifted multiplicand whenever the multiplier LSB is set.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p1  <= {{WIDTH{1'b0}}, mag_a};
      mplier_p1 <= mag_b;
      acc_p1    <= '0;
    end else if (step) begin
      if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  assign mag_product = acc_p1;

endmodule

// File: rtl/mul8_rr_sched.sv
// Round-robin scheduler sharing one sequential signed multiplier between two requesters.
module mul8_rr_sched
  import mul8_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic signed [WIDTH-1:0]   a0,
  input  logic signed [WIDTH-1:0]   b0,
  input  logic signed [WIDTH-1:0]   a1,
  input  logic signed [WIDTH-1:0]   b1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output req_id_t                   rsp_id,
  output logic signed [2*WIDTH-1:0] rsp_product,
  output logic                      busy
);

  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t                  state_q, state_d;
  req_id_t                 last_grant_q, grant;
  logic                    accept, start, step;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic                    sign_p1;
  logic [WIDTH-1:0]        mag_a, mag_b;
  logic [2*WIDTH-1:0]      mag_product;

  // Re-apply the product sign; a zero magnitude stays zero either way.
  function automatic logic signed [2*WIDTH-1:0] restore_sign(input logic neg,
                                                             input logic [2*WIDTH-1:0] m);
    logic [2*WIDTH-1:0] r;
    r = neg ? -m : m;
    return $signed(r);
  endfunction

  // Arbitration: contention goes to the requester not served last; ready only in IDLE.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) grant = ~last_grant_q;
    else if (req_valid[1])  grant = 1'b1;
    req_ready = 2'b00;
    if (rst_n && (state_q == S_IDLE) && (req_valid != 2'b00)) req_ready[grant] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  // Next-state and per-state strobes.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    step      = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: begin
        start   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_SIGN;
      end
      S_SIGN: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, arbitration history, response tag and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      rsp_id       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant;
        rsp_id       <= grant;
      end
      if (start)     cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---- stage p0: operands captured on the accepting edge ----
  // ---- stage p1: product sign captured while the core is loaded ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= grant ? a1 : a0;
      b_p0 <= grant ? b1 : b0;
    end
    if (start) sign_p1 <= a_p0[WIDTH-1] ^ b_p0[WIDTH-1];
  end

  assign mag_a = magnitude(a_p0);
  assign mag_b = magnitude(b_p0);

  mul8_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .start       (start),
    .step        (step),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .mag_product (mag_product)
  );

  // ---- stage p2: signed result registered in SIGN, held through RESP ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rsp_product <= '0;
    else if (state_q == S_SIGN) rsp_product <= restore_sign(sign_p1, mag_product);
  end

endmodule

// File: tb/tb_mul8_rr_sched.sv
// Randomized self-checking bench for mul8_rr_sched with a request-level reference model.
module tb_mul8_rr_sched;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic signed [7:0] a0, b0, a1, b1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic signed [15:0] rsp_product;
  logic              busy;

  mul8_rr_sched #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .a0          (a0),
    .b0          (b0),
    .a1          (a1),
    .b1          (b1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks;
  int n_errors;

  // Reference model: who is waiting, with which operands, and who was served last.
  logic              last_g;
  logic              pend [2];
  logic signed [7:0] pa [2];
  logic signed [7:0] pb [2];
  int                prev_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic raise(input int i, input logic signed [7:0] a, input logic signed [7:0] b);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    if (i == 0) begin a0 = a; b0 = b; end
    else        begin a1 = a; b1 = b; end
    req_valid[i] = 1'b1;
  endtask

  function automatic logic signed [7:0] pick_operand();
    logic signed [7:0] v;
    case ($urandom_range(0, 5))
      0:       v = -8'sd128;
      1:       v = 8'sd127;
      2:       v = 8'sd0;
      3:       v = -8'sd1;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // Serve one job: expected grant from the model, then latency, tag, product and hold behaviour.
  task automatic serve(input int hold, input bit scramble, input bit tp);
    int g, k, lat;
    logic signed [15:0] exp_p;
    if (pend[0] && pend[1]) g = last_g ? 0 : 1;
    else if (pend[1])       g = 1;
    else                    g = 0;
    exp_p = 16'(int'(pa[g]) * int'(pb[g]));
    rsp_ready = (hold == 0);
    #1;
    k = 0;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check_val("grant", 32'(req_ready), (g == 0) ? 32'd1 : 32'd2);
    if (req_ready == 2'b00) return;
    if (tp) check_val("period", 32'(cyc - prev_acc), 32'd12);
    prev_acc = cyc;
    last_g   = g[0];
    pend[g]  = 1'b0;
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    if (scramble) begin
      if (g == 0) begin a0 = ~pa[0]; b0 = 8'($urandom); end
      else        begin a1 = ~pa[1]; b1 = 8'($urandom); end
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check_val("busy_load", 32'(busy), 32'd1);
        check_val("ready_load", 32'(req_ready), 32'd0);
      end
    end
    check_val("latency", 32'(lat), 32'd11);
    check_val("rsp_id", 32'(rsp_id), 32'(g));
    check_val("product", 32'(rsp_product), 32'(exp_p));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_product", 32'(rsp_product), 32'(exp_p));
      check_val("hold_id", 32'(rsp_id), 32'(g));
      check_val("hold_ready", 32'(req_ready), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check_val("resp_last", 32'(rsp_valid), 32'd1);
    end
    @(negedge clk);
    check_val("idle_valid", 32'(rsp_valid), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_checks  = 0;
    n_errors  = 0;
    last_g    = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 2; i++) begin pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
    rst_n     = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    a0 = 8'sd7; b0 = 8'sd6; a1 = '0; b1 = '0;

    // Reset values, with a request pending so ready is known to be forced low.
    repeat (3) @(negedge clk);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_id", 32'(rsp_id), 32'd0);
    check_val("rst_product", 32'(rsp_product), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic product and signed corners, one job each.
    raise(0, 8'sd7, 8'sd6);      serve(0, 0, 0);
    raise(0, -8'sd128, -8'sd128); serve(0, 0, 0);
    raise(0, -8'sd128, 8'sd127);  serve(0, 0, 0);
    raise(0, -8'sd5, 8'sd0);      serve(0, 0, 0);
    raise(0, -8'sd3, 8'sd4);      serve(0, 0, 0);

    // Both requesters continuously valid: grants alternate at full throughput.
    raise(0, 8'sd2, 8'sd3);
    raise(1, 8'sd4, 8'sd5);
    for (int j = 0; j < 4; j++) begin
      serve(0, 0, j > 0);
      if (last_g == 1'b0) raise(0, 8'sd2, 8'sd3);
      else                raise(1, 8'sd4, 8'sd5);
    end

    // Back-pressure with the other requester waiting, then operand changes after acceptance.
    serve(5, 0, 0);
    serve(0, 1, 0);

    // Random traffic.
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1)) raise(i, pick_operand(), pick_operand());
      if (!pend[0] && !pend[1]) raise(int'($urandom_range(0, 1)), pick_operand(), pick_operand());
      serve(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), 0);
    end
    while (pend[0] || pend[1]) serve(0, 0, 0);

    // Reset during RUN aborts the job and restores requester-0 priority.
    raise(1, 8'sd9, 8'sd9);
    #1;
    k = 0;
    while (req_ready == 2'b00 && k < 20) begin @(negedge clk); #1; k++; end
    check_val("abort_grant", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    pend[1]      = 1'b0;
    repeat (4) @(negedge clk);
    check_val("abort_busy_run", 32'(busy), 32'd1);
    raise(0, -8'sd7, 8'sd11);
    raise(1, 8'sd3, 8'sd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_valid", 32'(rsp_valid), 32'd0);
    check_val("abort_ready", 32'(req_ready), 32'd0);
    check_val("abort_id", 32'(rsp_id), 32'd0);
    check_val("abort_product", 32'(rsp_product), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_val("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n  = 1'b1;
    last_g = 1'b1;
    serve(0, 0, 0);
    serve(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
